strength_net_resolver: RTL
==========================

Name: strength_net_resolver

Overview:
- Registered multi-driver net resolver for the signal-strength feature set.
- Sits directly upstream of any consumer of a multiply-driven net. Each of N_DRV driver ports posts a value and a strength; the block resolves them to a single net value using IEEE 1800 strength rules.
- Models trireg-style charge retention with timed decay when all drivers release.
- Supplies the resolved value plus X/Z/conflict status to downstream checkers.

Parameters:
- N_DRV, 3, number of driver ports (2..8).
- DECAY_CYCLES, 16, cycles a stored charge is held before the net floats; 0 means float immediately.
- CHARGE_STR, 2, strength reported while holding charge (2 = medium).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- drv_we  input  N_DRV  per-driver update strobe; latches that driver's value and strength.
- drv_rel  input  N_DRV  per-driver release strobe; sets that driver's strength to 0 (highz).
- drv_val  input  N_DRV  per-driver logic value.
- drv_str  input  3*N_DRV  per-driver strength, 3 bits each; driver i uses bits [3i+2:3i]. Encoding: 0 highz, 1 small, 2 medium, 3 weak, 4 large, 5 pull, 6 strong, 7 supply.
- o_val  output  1  resolved value; 0 when o_x or o_z is set.
- o_x  output  1  resolved value is unknown.
- o_z  output  1  net is floating.
- o_str  output  3  strength of the resolved value.
- o_charged  output  1  net is holding stored charge.
- conflict_cnt  output  8  saturating count of conflict entries.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - All driver registers go to strength 0, value 0.
  - o_val=0, o_x=0, o_z=1, o_str=0, o_charged=0.
  - Decay counter = 0, conflict_cnt = 0.
- Stage 1 (driver registers):
  - drv_we[i] sampled high latches drv_val[i] and drv_str[i].
  - drv_rel[i] sampled high sets strength[i] = 0.
  - drv_we and drv_rel high together on the same driver: drv_we wins.
  - drv_we with drv_str = 0 is equivalent to a release.
- Stage 2 (resolution, registered):
  - S = maximum strength across the driver registers.
  - S > 0, and every driver at strength S carries the same value v: o_val=v, o_str=S, o_x=0, o_z=0, o_charged=0.
  - S > 0, with both 0 and 1 present at strength S: o_x=1, o_val=0, o_str=S, o_z=0, o_charged=0. Weaker drivers are ignored in both cases.
- Latency: a strobe sampled at edge t updates the outputs at edge t+1 (outputs visible two edges after the strobe is presented). There is no backpressure; every strobe is accepted.
- Charge (S = 0):
  - Previous output driven (o_z=0, o_charged=0) and DECAY_CYCLES > 0:
    - Enter charged: o_charged=1, o_str=CHARGE_STR.
    - o_val and o_x hold their previous values (X charge stays X).
    - Decay counter loads DECAY_CYCLES-1.
  - While charged with S = 0: the counter decrements each cycle. On the cycle it reads 0, the next edge sets o_z=1, o_charged=0, o_val=0, o_x=0, o_str=0.
  - Charged state therefore lasts exactly DECAY_CYCLES cycles.
  - DECAY_CYCLES = 0: S = 0 goes directly to float.
  - Already floating with S = 0: stay floating.
- Any S > 0 while charged: counter clears and normal resolution applies on that edge.
- conflict_cnt:
  - Increments by 1 on each edge where o_x goes from 0 to 1 through driven resolution, not through charge.
  - Saturates at 255.
  - Continuous conflict counts once.
- Async reset mid-charge or mid-conflict clears all state immediately; no stale charge survives.

Test Plan:
1. Weak-vs-strong: drivers 0,1 strobed to (1, weak=3) and driver 2 to (0, strong=6) in one cycle -> two edges later o_val=0, o_str=6, o_x=0, o_z=0.
2. Equal-strength conflict: driver 0 (1,6), driver 1 (0,6), held for 5 cycles -> o_x=1, o_str=6, conflict_cnt=1. Then raise driver 1 to supply=7 -> o_x=0, o_val=0, o_str=7.
3. Charge decay (DECAY_CYCLES=4): drive (1,6), then release all -> o_charged=1, o_val=1, o_str=2 for exactly 4 cycles, then o_z=1, o_str=0.
4. Re-drive during charge: at decay cycle 2, drv_we driver 2 with (0,5) -> o_charged=0, o_val=0, o_str=5. A later full release restarts the full 4-cycle decay.
5. Simultaneous strobes: drv_we[0] and drv_rel[0] high together with (1,3) -> driver retained, o_val=1, o_str=3. drv_we with str=0 -> behaves as a release.
6. Reset mid-charge: assert rst_n low during charge (async, between edges) -> all outputs immediately at reset values, o_z=1, conflict_cnt=0. After deassert with no strobes, o_z stays 1.

Source files
------------

// File: rtl/strength_net_resolver.sv
// strength_net_resolver
// Registered resolver for a net with several drivers. Each driver port keeps a
// latched (value, strength) pair. Every edge the block resolves those pairs to
// one net value using IEEE 1800 strength rules. When every driver lets go, the
// net keeps its last value as stored charge and floats after a timed decay.
//
// Strobe semantics: drv_we[i] and drv_rel[i] are single-cycle strobes sampled
// on the rising edge. Every strobe is accepted (no ready, no backpressure).
// If drv_we[i] and drv_rel[i] are high together, drv_we[i] wins. A strobe at
// edge t reaches the outputs at edge t+1.
//
// Net mode is visible on the outputs:
//   o_z=1                 floating
//   o_charged=1           holding charge
//   o_z=0, o_charged=0    driven
module strength_net_resolver #(
  parameter int N_DRV        = 3,
  parameter int DECAY_CYCLES = 16,
  parameter int CHARGE_STR   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_DRV-1:0]     drv_we,
  input  logic [N_DRV-1:0]     drv_rel,
  input  logic [N_DRV-1:0]     drv_val,
  input  logic [3*N_DRV-1:0]   drv_str,
  output logic                 o_val,
  output logic                 o_x,
  output logic                 o_z,
  output logic [2:0]           o_str,
  output logic                 o_charged,
  output logic [7:0]           conflict_cnt
);

  // Decay counter width. It only has to hold DECAY_CYCLES-1.
  localparam int CW = (DECAY_CYCLES > 1) ? $clog2(DECAY_CYCLES) : 1;
  localparam logic [CW-1:0] DECAY_LOAD =
    (DECAY_CYCLES > 0) ? CW'(DECAY_CYCLES - 1) : '0;
  localparam logic [2:0] CHARGE_S = 3'(CHARGE_STR);

  // Stage 1 driver registers
  logic [N_DRV-1:0] val_q;
  logic [2:0]       str_q [N_DRV];

  // Resolution terms
  logic [2:0] s_max;
  logic       has0;
  logic       has1;

  // Decay counter and next-state values
  logic [CW-1:0] dcnt_q;
  logic [CW-1:0] nxt_dcnt;
  logic          nxt_val;
  logic          nxt_x;
  logic          nxt_z;
  logic [2:0]    nxt_str;
  logic          nxt_chg;
  logic [7:0]    nxt_cc;
  logic          conflict_entry;

  // Stage 1: latch value and strength per driver. A write beats a release,
  // and a write of strength 0 lands as a release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q <= '0;
      for (int i = 0; i < N_DRV; i++) begin
        str_q[i] <= 3'd0;
      end
    end else begin
      for (int i = 0; i < N_DRV; i++) begin
        if (drv_we[i]) begin
          val_q[i] <= drv_val[i];
          str_q[i] <= drv_str[3*i +: 3];
        end else if (drv_rel[i]) begin
          str_q[i] <= 3'd0;
        end
      end
    end
  end

  // Find the strongest strength.
  // Then find which logic values are present at that strength.
  always_comb begin
    s_max = 3'd0;
    has0  = 1'b0;
    has1  = 1'b0;
    for (int i = 0; i < N_DRV; i++) begin
      if (str_q[i] > s_max) begin
        s_max = str_q[i];
      end
    end
    for (int i = 0; i < N_DRV; i++) begin
      if ((s_max != 3'd0) && (str_q[i] == s_max)) begin
        if (val_q[i]) begin
          has1 = 1'b1;
        end else begin
          has0 = 1'b0 | 1'b1;
        end
      end
    end
  end

  // Next output state.
  // Cases: driven resolution, charge entry, charge decay, or float.
  always_comb begin
    nxt_val  = o_val;
    nxt_x    = o_x;
    nxt_z    = o_z;
    nxt_str  = o_str;
    nxt_chg  = o_charged;
    nxt_dcnt = dcnt_q;
    if (s_max != 3'd0) begin
      // At least one driver is active. Drivers weaker than s_max are ignored.
      nxt_x    = has0 & has1;
      nxt_val  = has1 & ~has0;
      nxt_str  = s_max;
      nxt_z    = 1'b0;
      nxt_chg  = 1'b0;
      nxt_dcnt = '0;
    end else if (o_charged) begin
      if (dcnt_q == '0) begin
        nxt_z    = 1'b1;
        nxt_chg  = 1'b0;
        nxt_val  = 1'b0;
        nxt_x    = 1'b0;
        nxt_str  = 3'd0;
      end else begin
        nxt_dcnt = dcnt_q - 1'b1;
      end
    end else if (!o_z) begin
      // The net was driven and every driver has now let go.
      if (DECAY_CYCLES > 0) begin
        // Keep the last value (an X value stays X) and start the decay.
        nxt_chg  = 1'b1;
        nxt_str  = CHARGE_S;
        nxt_dcnt = DECAY_LOAD;
      end else begin
        nxt_z    = 1'b1;
        nxt_val  = 1'b0;
        nxt_x    = 1'b0;
        nxt_str  = 3'd0;
      end
    end
  end

  // A conflict is counted only when a driven resolution turns o_x from 0 to 1.
  // Holding the same conflict counts once, and charge never counts.
  always_comb begin
    conflict_entry = (s_max != 3'd0) && has0 && has1 && !o_x;
    nxt_cc         = conflict_cnt;
    if (conflict_entry && (conflict_cnt != 8'hFF)) begin
      nxt_cc = conflict_cnt + 8'd1;
    end
  end

  // Stage 2: output, decay counter and conflict counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_val        <= 1'b0;
      o_x          <= 1'b0;
      o_z          <= 1'b1;
      o_str        <= 3'd0;
      o_charged    <= 1'b0;
      dcnt_q       <= '0;
      conflict_cnt <= 8'd0;
    end else begin
      o_val        <= nxt_val;
      o_x          <= nxt_x;
      o_z          <= nxt_z;
      o_str        <= nxt_str;
      o_charged    <= nxt_chg;
      dcnt_q       <= nxt_dcnt;
      conflict_cnt <= nxt_cc;
    end
  end

endmodule
